// File: rtl/problem_sequencer.sv
// Problem sequencer for the alarm puzzle: draws operands/op from an LFSR, drives the shared ALU,
// latches the expected result and grades player answers. Optional answer timeout: PROB_TIMEOUT_EN.
module problem_sequencer #(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          OPERAND_BITS   = 7,
  parameter logic [4:0]  OP_MASK        = 5'b11111,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic [2:0] alu_operation,
  input  logic [7:0] alu_result,
  output logic       prob_valid,
  output logic       busy,
  input  logic       answer_valid,
  input  logic [7:0] answer,
  output logic       check_done,
  output logic       correct,
  output logic [3:0] wrong_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_PRESENT,
    S_CHECK
  } state_t;

  localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [7:0]  OPND_MASK = 8'((9'd1 << OPERAND_BITS) - 9'd1);
  localparam logic [7:0]  OP_EN     = {3'b000, OP_MASK};

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [2:0]  rej_cnt;
  logic [7:0]  expected;

  logic [2:0]  cand_op;
  logic        cand_ok;
  logic        force_op;
  logic        gen_take;
  logic [2:0]  gen_op;
  logic [7:0]  gen_a;
  logic [7:0]  gen_b;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

`ifdef PROB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        tmo_q;

  assign tmo_hit = (state == S_PRESENT) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

  // Candidate problem from the current LFSR value
  always_comb begin
    cand_op  = lfsr[2:0];
    cand_ok  = (cand_op < 3'd5) && OP_EN[cand_op];
    force_op = (rej_cnt == 3'd7);
    gen_take = cand_ok || force_op;
    gen_op   = force_op ? 3'd0 : cand_op;
    gen_a    = lfsr[15:8] & OPND_MASK;
    gen_b    = lfsr[7:0] & OPND_MASK;
    case (gen_op)
      3'd1: begin
        if (gen_a < gen_b) begin
          gen_a = lfsr[7:0] & OPND_MASK;
          gen_b = lfsr[15:8] & OPND_MASK;
        end
      end
      3'd2: begin
        gen_a = gen_a & 8'h0F;
        gen_b = gen_b & 8'h0F;
      end
      3'd3, 3'd4: begin
        if (gen_b == 8'd0) gen_b = 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_GEN;
      S_GEN:     if (gen_take) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (answer_valid) state_nxt = S_CHECK;
`ifdef PROB_TIMEOUT_EN
        else if (tmo_hit) state_nxt = S_CHECK;
`endif
        else if (start) state_nxt = S_GEN;
      end
      S_CHECK: begin
        if (correct) state_nxt = S_IDLE;
`ifdef PROB_TIMEOUT_EN
        else if (tmo_q) state_nxt = S_GEN;
`endif
        else state_nxt = S_PRESENT;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (state == S_GEN) || (state == S_ISSUE);
  assign prob_valid = (state == S_PRESENT) || (state == S_CHECK);
  assign check_done = (state == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_INIT;
      rej_cnt <= 3'd0;
    end else begin
      lfsr    <= lfsr_step(lfsr);
      rej_cnt <= ((state == S_GEN) && !gen_take) ? rej_cnt + 3'd1 : 3'd0;
    end
  end

  // Issue registers: held from acceptance through PRESENT so they double as the display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operand1  <= 8'd0;
      alu_operand2  <= 8'd0;
      alu_operation <= 3'd0;
      expected      <= 8'd0;
    end else begin
      if ((state == S_GEN) && gen_take) begin
        alu_operand1  <= gen_a;
        alu_operand2  <= gen_b;
        alu_operation <= gen_op;
      end
      if (state == S_ISSUE) expected <= alu_result;
    end
  end

  // Grading: results become visible together with check_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      correct   <= 1'b0;
      wrong_cnt <= 4'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        correct   <= 1'b0;
        wrong_cnt <= 4'd0;
      end else if ((state == S_PRESENT) && answer_valid) begin
        correct <= (answer == expected);
        if (answer != expected) wrong_cnt <= sat_inc(wrong_cnt);
      end
`ifdef PROB_TIMEOUT_EN
      else if (tmo_hit) begin
        correct   <= 1'b0;
        wrong_cnt <= sat_inc(wrong_cnt);
      end
`endif
    end
  end

`ifdef PROB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_PRESENT) ? tmo_cnt + 16'd1 : 16'd0;
      tmo_q   <= tmo_hit && !answer_valid;
    end
  end
`endif

endmodule
